// File: rtl/usb_mouse_pkg.sv
// Shared types for the USB mouse to PS/2 packer: event word layout, flag bits,
// PS/2 delta limits, FSM states and a saturating 16-bit add.
package usb_mouse_pkg;

    typedef struct packed {
        logic       toggle;
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] flags;
    } ps2_mouse_t;

    localparam int FLG_YOVF = 7;
    localparam int FLG_XOVF = 6;
    localparam int FLG_YSGN = 5;
    localparam int FLG_XSGN = 4;
    localparam int FLG_ONE  = 3;

    localparam int PS2_MIN = -256;
    localparam int PS2_MAX = 255;

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_EMIT} state_e;

    function automatic logic signed [15:0] sat_add16(input logic signed [15:0] a,
                                                     input logic signed [15:0] b);
        logic signed [16:0] s;
        s = $signed({a[15], a}) + $signed({b[15], b});
        if (s > 17'sd32767)
            return 16'sh7FFF;
        else if (s < -17'sd32768)
            return 16'sh8000;
        return s[15:0];
    endfunction

endpackage

// File: rtl/usb_mouse_ps2_packer_if.sv
// Decoded-report inputs and PS/2 event outputs of the packer.
interface usb_mouse_ps2_packer_if;
    import usb_mouse_pkg::*;

    logic               mouse_valid;
    logic [15:0]        report_cnt;
    logic [2:0]         buttons;
    logic signed [15:0] mouse_dx;
    logic signed [15:0] mouse_dy;
    ps2_mouse_t         ps2_mouse;
    logic               pending;

    modport master (output mouse_valid, report_cnt, buttons, mouse_dx, mouse_dy,
                    input  ps2_mouse, pending);
    modport slave  (input  mouse_valid, report_cnt, buttons, mouse_dx, mouse_dy,
                    output ps2_mouse, pending);
endinterface

// File: rtl/usb_mouse_sat_acc.sv
// One motion axis: saturating accumulator, 9-bit PS/2 clamp with overflow flag.
// USB_MOUSE_ACCUM_EN keeps the unsent residual after emit; otherwise latest report wins.
module usb_mouse_sat_acc
    import usb_mouse_pkg::*;
#(
    parameter bit NEG = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               add,
    input  logic               emit,
    input  logic signed [15:0] delta,
    output logic [8:0]         p,
    output logic               ovf,
    output logic               nz
);

    logic signed [15:0] acc, acc_nx;
    logic signed [16:0] a17, v;

    // Y is negated before clamping; -(-32768) fits in 17 bits and clamps the same.
    always_comb begin
        a17 = $signed({acc[15], acc});
        v   = NEG ? -a17 : a17;
        if (v > $signed(17'(PS2_MAX))) begin
            p   = 9'h0FF;
            ovf = 1'b1;
        end else if (v < $signed(17'(PS2_MIN))) begin
            p   = 9'h100;
            ovf = 1'b1;
        end else begin
            p   = v[8:0];
            ovf = 1'b0;
        end
    end

`ifdef USB_MOUSE_ACCUM_EN
    logic signed [15:0] p16, res, base;
    always_comb begin
        p16    = $signed({{7{p[8]}}, p});
        res    = NEG ? acc + p16 : acc - p16;
        base   = emit ? res : acc;
        acc_nx = add ? sat_add16(base, delta) : base;
    end
`else
    always_comb begin
        acc_nx = add ? delta : (emit ? 16'sd0 : acc);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc <= '0;
        else          acc <= acc_nx;
    end

    assign nz = (acc != 16'sd0);

endmodule

// File: rtl/usb_mouse_ps2_packer.sv
// Turns decoded USB mouse reports into rate-limited MiSTer ps2_mouse event words.
// Optional residual accumulation: `define USB_MOUSE_ACCUM_EN.
module usb_mouse_ps2_packer
    import usb_mouse_pkg::*;
#(
    parameter int MIN_GAP = 48000,
    parameter int GAP_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    usb_mouse_ps2_packer_if.slave  bus
);

    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(MIN_GAP);

    logic               r_valid, armed, more;
    logic [15:0]        r_cnt, last_cnt;
    logic [2:0]         r_btn, cur_btn, last_btn, btn_ref;
    logic signed [15:0] r_dx, r_dy;
    logic               new_rep, evt, emit_now;
    logic [8:0]         px, py;
    logic               x_ovf, y_ovf, x_nz, y_nz;
    logic [7:0]         flags;
    logic [GAP_W-1:0]   gap_cnt;
    state_e             state;
    ps2_mouse_t         pkt;

    assign emit_now = (state == ST_PEND) && (gap_cnt == '0);
    assign new_rep  = armed && r_valid && (r_cnt != last_cnt);
    // Compare against the buttons leaving in this cycle's packet when emitting.
    assign btn_ref  = emit_now ? cur_btn : last_btn;
    assign evt      = new_rep && (r_dx != 16'sd0 || r_dy != 16'sd0 || r_btn != btn_ref);

    always_comb begin
        flags           = '0;
        flags[2:0]      = cur_btn;
        flags[FLG_ONE]  = 1'b1;
        flags[FLG_XSGN] = px[8];
        flags[FLG_YSGN] = py[8];
        flags[FLG_XOVF] = x_ovf;
        flags[FLG_YOVF] = y_ovf;
    end

    // armed lets last_cnt load the live counter once after reset, so a nonzero
    // counter present at release is not mistaken for a new report.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_btn    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            armed    <= 1'b0;
            last_cnt <= '0;
            cur_btn  <= '0;
        end else begin
            r_valid <= bus.mouse_valid;
            r_cnt   <= bus.report_cnt;
            r_btn   <= bus.buttons;
            r_dx    <= bus.mouse_dx;
            r_dy    <= bus.mouse_dy;
            armed   <= 1'b1;
            if (!armed)                  last_cnt <= bus.report_cnt;
            else if (!r_valid || new_rep) last_cnt <= r_cnt;
            if (new_rep) cur_btn <= r_btn;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            pkt      <= '0;
            last_btn <= '0;
            more     <= 1'b0;
        end else begin
            if (emit_now)            gap_cnt <= GAP_LD;
            else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
            case (state)
                ST_IDLE: if (evt) state <= ST_PEND;
                ST_PEND: if (emit_now) begin
                    state      <= ST_EMIT;
                    pkt.flags  <= flags;
                    pkt.x      <= px[7:0];
                    pkt.y      <= py[7:0];
                    pkt.toggle <= ~pkt.toggle;
                    last_btn   <= cur_btn;
                    more       <= evt;
                end
                ST_EMIT: state <= (more || evt || x_nz || y_nz) ? ST_PEND : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    usb_mouse_sat_acc #(.NEG(1'b0)) u_acc_x (
        .clk(clk), .reset_n(reset_n), .add(evt), .emit(emit_now),
        .delta(r_dx), .p(px), .ovf(x_ovf), .nz(x_nz)
    );

    usb_mouse_sat_acc #(.NEG(1'b1)) u_acc_y (
        .clk(clk), .reset_n(reset_n), .add(evt), .emit(emit_now),
        .delta(r_dy), .p(py), .ovf(y_ovf), .nz(y_nz)
    );

    assign bus.ps2_mouse = pkt;
    assign bus.pending   = (state == ST_PEND);

endmodule

// File: tb/tb_usb_mouse_ps2_packer.sv
// Directed bench for usb_mouse_ps2_packer with an expected-packet scoreboard.
module tb_usb_mouse_ps2_packer;
    import usb_mouse_pkg::*;

    localparam int MIN_GAP = 8;
    localparam int GAP_W   = 4;

    typedef struct packed { logic [7:0] f; logic [7:0] x; logic [7:0] y; } exp_t;
    typedef struct packed { logic [24:0] w; logic [31:0] cyc; } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_cyc = 0;
    int   t0 = 0;
    logic exp_tog = 1'b0;
    logic prev_tog = 1'b0;
    exp_t exp_q[$];
    obs_t obs_q[$];

    usb_mouse_ps2_packer_if bus();

    usb_mouse_ps2_packer #(.MIN_GAP(MIN_GAP), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Capture every toggle flip as one emitted packet.
    always @(negedge clk) begin
        if (reset_n && bus.ps2_mouse.toggle !== prev_tog)
            obs_q.push_back({bus.ps2_mouse, 32'(cyc)});
        prev_tog = bus.ps2_mouse.toggle;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] cnt, input logic [2:0] btn,
                         input int dx, input int dy);
        bus.report_cnt = cnt;
        bus.buttons    = btn;
        bus.mouse_dx   = 16'(dx);
        bus.mouse_dy   = 16'(dy);
        t0 = cyc;
    endtask

    task automatic expect_pkt(input string tag, input int exp_cyc);
        exp_t e;
        obs_t o;
        int   n;
        n = 0;
        while (obs_q.size() == 0 && n < 40) begin
            step(1);
            n++;
        end
        e = exp_q.pop_front();
        exp_tog = ~exp_tog;
        chk({tag, "_arrived"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            last_cyc = int'(o.cyc);
            chk({tag, "_flags"}, 32'(o.w[7:0]),   32'(e.f));
            chk({tag, "_x"},     32'(o.w[15:8]),  32'(e.x));
            chk({tag, "_y"},     32'(o.w[23:16]), 32'(e.y));
            chk({tag, "_tog"},   32'(o.w[24]),    32'(exp_tog));
            if (exp_cyc >= 0) chk({tag, "_cycle"}, o.cyc, 32'(exp_cyc));
        end
    endtask

    initial begin
        bus.mouse_valid = 1'b1;
        drive(16'h0000, 3'b000, 0, 0);
        step(3);
        chk("reset_ps2", 32'(bus.ps2_mouse), 32'h0);
        chk("reset_pending", 32'(bus.pending), 32'h0);
        reset_n = 1'b1;
        step(4);
        chk("no_pkt_after_reset", 32'(obs_q.size()), 32'd0);

        // Basic report: flags 29, X 0A, Y FB, three cycles after the change.
        drive(16'h0001, 3'b001, 10, 5);
        exp_q.push_back('{f: 8'h29, x: 8'h0A, y: 8'hFB});
        step(2);
        chk("basic_pending", 32'(bus.pending), 32'd1);
        chk("basic_not_yet", 32'(bus.ps2_mouse), 32'h0);
        expect_pkt("basic", t0 + 3);
        step(12);

        // Counter moves while not a mouse; becoming valid raises nothing.
        bus.mouse_valid = 1'b0;
        drive(16'h0005, 3'b001, 10, 5);
        step(3);
        bus.mouse_valid = 1'b1;
        step(12);
        chk("invalid_no_pkt", 32'(obs_q.size()), 32'd0);
        chk("invalid_tog", 32'(bus.ps2_mouse.toggle), 32'd1);
        chk("invalid_pending", 32'(bus.pending), 32'd0);

        // Button-only packets, including counter wrap FFFF -> 0000.
        bus.mouse_valid = 1'b0;
        drive(16'hFFFE, 3'b001, 0, 0);
        step(3);
        bus.mouse_valid = 1'b1;
        step(3);
        drive(16'hFFFF, 3'b000, 0, 0);
        exp_q.push_back('{f: 8'h08, x: 8'h00, y: 8'h00});
        expect_pkt("btn_release", t0 + 3);
        step(12);
        drive(16'h0000, 3'b010, 0, 0);
        exp_q.push_back('{f: 8'h0A, x: 8'h00, y: 8'h00});
        expect_pkt("wrap_btn", t0 + 3);
        step(12);

        // Large X motion: clamped, spread over packets only with accumulation.
        drive(16'h0001, 3'b010, 600, 0);
`ifdef USB_MOUSE_ACCUM_EN
        exp_q.push_back('{f: 8'h4A, x: 8'hFF, y: 8'h00});
        exp_q.push_back('{f: 8'h4A, x: 8'hFF, y: 8'h00});
        exp_q.push_back('{f: 8'h0A, x: 8'h5A, y: 8'h00});
        expect_pkt("big_1", t0 + 3);
        expect_pkt("big_2", t0 + 3 + (MIN_GAP + 1));
        expect_pkt("big_3", t0 + 3 + 2 * (MIN_GAP + 1));
`else
        exp_q.push_back('{f: 8'h4A, x: 8'hFF, y: 8'h00});
        expect_pkt("big_1", t0 + 3);
`endif
        step(25);
        chk("big_no_extra", 32'(obs_q.size()), 32'd0);

        // Two reports inside one gap window.
        drive(16'h0002, 3'b010, 1, 0);
        exp_q.push_back('{f: 8'h0A, x: 8'h01, y: 8'h00});
        expect_pkt("gap_lead", t0 + 3);
        drive(16'h0003, 3'b010, 3, 0);
        step(3);
        drive(16'h0004, 3'b010, 3, 0);
`ifdef USB_MOUSE_ACCUM_EN
        exp_q.push_back('{f: 8'h0A, x: 8'h06, y: 8'h00});
`else
        exp_q.push_back('{f: 8'h0A, x: 8'h03, y: 8'h00});
`endif
        expect_pkt("gap_merge", last_cyc + MIN_GAP + 1);
        step(15);
        chk("gap_no_extra", 32'(obs_q.size()), 32'd0);

        // Asynchronous reset while an event is held discards it.
        drive(16'h0005, 3'b010, 7, 0);
        step(2);
        chk("rst_pend_before", 32'(bus.pending), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ps2_now", 32'(bus.ps2_mouse), 32'h0);
        chk("rst_pending_now", 32'(bus.pending), 32'd0);
        exp_tog = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(15);
        chk("rst_no_pkt", 32'(obs_q.size()), 32'd0);

        // Negative motion after reset.
        drive(16'h0006, 3'b010, -3, -2);
        exp_q.push_back('{f: 8'h1A, x: 8'hFD, y: 8'h02});
        expect_pkt("neg", t0 + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
